// File: rtl/fa_response_checker_if.sv
// Stimulus/response and status bundle between the full-adder response checker and its environment.
interface fa_response_checker_if;
  logic       start;
  logic       dut_sum;
  logic       dut_cout;
  logic       A;
  logic       B;
  logic       Cin;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_fail;

  modport master (
    input  start, dut_sum, dut_cout,
    output A, B, Cin, busy, done, pass, err_count, first_fail
  );

  modport slave (
    output start, dut_sum, dut_cout,
    input  A, B, Cin, busy, done, pass, err_count, first_fail
  );
endinterface

// File: rtl/fa_response_checker.sv
// Exhaustive full-adder response checker: sweeps {A,B,Cin} 000..111 and compares the DUT response.
// Optional macro FA_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module fa_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  fa_response_checker_if.master       bus
);

  localparam int unsigned HoldW   = 4;
  localparam int unsigned VecW    = 3;
  localparam int unsigned ErrW    = 4;
  localparam logic [HoldW-1:0] HoldReload = HoldW'(SETTLE_CYCLES - 1);

`ifdef FA_CHK_STOP_ON_FAIL_EN
  localparam bit StopOnFail = 1'b1;
`else
  localparam bit StopOnFail = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [VecW-1:0]   vec_q, vec_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ErrW-1:0]   err_q, err_d;
  logic [VecW-1:0]   ff_q, ff_d;

  logic exp_sum_c, exp_cout_c, mismatch_c;

  // Golden full-adder response for the vector currently on the DUT.
  assign exp_sum_c  = vec_q[2] ^ vec_q[1] ^ vec_q[0];
  assign exp_cout_c = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
  assign mismatch_c = (bus.dut_sum != exp_sum_c) || (bus.dut_cout != exp_cout_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        vec_d  = '0;
        if (bus.start) begin
          state_d = RUN;
          hold_d  = HoldReload;
          err_d   = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        if (hold_q != '0) begin
          hold_d = HoldW'(hold_q - HoldW'(1));
        end else begin
          if (mismatch_c) begin
            err_d = ErrW'(err_q + ErrW'(1));
            if (err_q == '0) ff_d = vec_q;
          end
          // Last vector (or first failure in stop-on-fail builds) ends the sweep.
          if ((vec_q == VecW'(7)) || (StopOnFail && mismatch_c)) begin
            state_d = DONE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d  = VecW'(vec_q + VecW'(1));
            hold_d = HoldReload;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        vec_d   = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        vec_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.A          = vec_q[2];
  assign bus.B          = vec_q[1];
  assign bus.Cin        = vec_q[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_fa_response_checker.sv
// Scoreboard bench for fa_response_checker with SETTLE_CYCLES=1 and =3 instances and a faultable adder model.
module tb_fa_response_checker;

  logic clk = 1'b0;
  logic rst;
  int   fault_mode;
  bit   sel3;
  int   n_checks = 0;
  int   n_pass   = 0;

  typedef struct {
    logic [3:0] err;
    logic [2:0] ff;
    logic       pass;
  } res_t;

  logic [2:0] exp_vec_q[$];
  res_t       exp_res_q[$];

  always #5 clk = ~clk;

  fa_response_checker_if if1 ();
  fa_response_checker_if if3 ();

  fa_response_checker #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.master));
  fa_response_checker #(.SETTLE_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.master));

  // Adder under test: 0 golden, 1 cout stuck at 0, 2 sum inverted.
  function automatic logic [1:0] fa_model(input logic [2:0] v, input int f);
    logic s, c;
    s = v[2] ^ v[1] ^ v[0];
    c = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    if (f == 1) c = 1'b0;
    if (f == 2) s = ~s;
    return {s, c};
  endfunction

  assign {if1.dut_sum, if1.dut_cout} = fa_model({if1.A, if1.B, if1.Cin}, fault_mode);
  assign {if3.dut_sum, if3.dut_cout} = fa_model({if3.A, if3.B, if3.Cin}, fault_mode);

  logic [2:0] obs_vec;
  logic       obs_busy, obs_done, obs_pass;
  logic [3:0] obs_err;
  logic [2:0] obs_ff;

  always_comb begin
    obs_vec  = sel3 ? {if3.A, if3.B, if3.Cin} : {if1.A, if1.B, if1.Cin};
    obs_busy = sel3 ? if3.busy : if1.busy;
    obs_done = sel3 ? if3.done : if1.done;
    obs_pass = sel3 ? if3.pass : if1.pass;
    obs_err  = sel3 ? if3.err_count : if1.err_count;
    obs_ff   = sel3 ? if3.first_fail : if1.first_fail;
  end

  task automatic drive_start(input bit v);
    if (sel3) if3.start = v; else if1.start = v;
  endtask

  // Reference sweep: per-cycle vectors plus final verdict, pushed before stimulus.
  task automatic push_expected(input int settle, input int f);
    res_t r;
    logic [2:0] v;
    logic [1:0] gold, got;
    r.err = '0; r.ff = '0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      for (int k = 0; k < settle; k++) exp_vec_q.push_back(v);
      gold = fa_model(v, 0);
      got  = fa_model(v, f);
      if (gold != got) begin
        if (r.err == 0) r.ff = v;
        r.err = 4'(r.err + 4'd1);
`ifdef FA_CHK_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    r.pass = (r.err == 0);
    exp_res_q.push_back(r);
  endtask

  task automatic do_sweep(input bit s3, input int f, input int poke_at);
    int   idx;
    logic [2:0] v;
    res_t r;
    sel3 = s3;
    fault_mode = f;
    push_expected(s3 ? 3 : 1, f);
    @(negedge clk);
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    idx = 0;
    while (exp_vec_q.size() > 0) begin
      v = exp_vec_q.pop_front();
      n_checks++;
      if (obs_vec !== v || obs_busy !== 1'b1 || obs_done !== 1'b0)
        $display("FAIL run_vec[%0d] got vec=%b busy=%b done=%b want vec=%b busy=1 done=0", idx, obs_vec, obs_busy, obs_done, v);
      else n_pass++;
      drive_start(idx == poke_at);
      idx++;
      @(negedge clk);
    end
    drive_start(1'b0);
    r = exp_res_q.pop_front();
    n_checks++;
    if (obs_done !== 1'b1 || obs_busy !== 1'b0 || obs_vec !== 3'b000 || obs_pass !== r.pass || obs_err !== r.err)
      $display("FAIL done_cycle got done=%b busy=%b vec=%b pass=%b err=%0d want done=1 busy=0 vec=000 pass=%b err=%0d",
               obs_done, obs_busy, obs_vec, obs_pass, obs_err, r.pass, r.err);
    else n_pass++;
    if (r.err != 0) begin
      n_checks++;
      if (obs_ff !== r.ff) $display("FAIL first_fail got %b want %b", obs_ff, r.ff);
      else n_pass++;
    end
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    n_checks++;
    if (obs_done !== 1'b0 || obs_busy !== 1'b0 || obs_pass !== r.pass || obs_err !== r.err)
      $display("FAIL idle_hold got done=%b busy=%b pass=%b err=%0d want done=0 busy=0 pass=%b err=%0d",
               obs_done, obs_busy, obs_pass, obs_err, r.pass, r.err);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (obs_busy !== 1'b0 || obs_vec !== 3'b000)
      $display("FAIL start_in_done_ignored got busy=%b vec=%b want busy=0 vec=000", obs_busy, obs_vec);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if1.start = 1'b0;
    if3.start = 1'b0;
    fault_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({if1.A, if1.B, if1.Cin, if1.busy, if1.done, if1.pass, if1.err_count, if1.first_fail} !== 13'd0 ||
        {if3.A, if3.B, if3.Cin, if3.busy, if3.done, if3.pass, if3.err_count, if3.first_fail} !== 13'd0)
      $display("FAIL reset_state got dut1=%b dut3=%b want all zero",
               {if1.A, if1.B, if1.Cin, if1.busy, if1.done, if1.pass, if1.err_count, if1.first_fail},
               {if3.A, if3.B, if3.Cin, if3.busy, if3.done, if3.pass, if3.err_count, if3.first_fail});
    else n_pass++;
  endtask

  task automatic test_golden;        do_sweep(1'b0, 0, -1); endtask
  task automatic test_cout_stuck;    do_sweep(1'b0, 1, -1); endtask
  task automatic test_sum_inverted;  do_sweep(1'b0, 2, -1); endtask
  task automatic test_settle3;       do_sweep(1'b1, 0, 10); endtask
  task automatic test_back_to_back;  do_sweep(1'b0, 1, -1); do_sweep(1'b0, 0, 3); endtask

  task automatic test_reset_mid_sweep;
    int saw_done;
    sel3 = 1'b0;
    fault_mode = 0;
    @(negedge clk);
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    for (int i = 0; i < 20 && obs_vec !== 3'b101; i++) @(negedge clk);
    n_checks++;
    if (obs_vec !== 3'b101) $display("FAIL reach_101 got %b want 101", obs_vec);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({if1.A, if1.B, if1.Cin, if1.busy, if1.done, if1.pass, if1.err_count, if1.first_fail} !== 13'd0)
      $display("FAIL reset_mid_sweep got %b want all zero",
               {if1.A, if1.B, if1.Cin, if1.busy, if1.done, if1.pass, if1.err_count, if1.first_fail});
    else n_pass++;
    saw_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (if1.done === 1'b1 || if1.busy === 1'b1) saw_done++;
      @(negedge clk);
    end
    n_checks++;
    if (saw_done != 0) $display("FAIL no_done_after_abort got %0d active cycles want 0", saw_done);
    else n_pass++;
    do_sweep(1'b0, 0, -1);
  endtask

  initial begin
    test_reset;
    test_golden;
    test_cout_stuck;
    test_sum_inverted;
    test_settle3;
    test_reset_mid_sweep;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
